// File: rtl/accel_pkg.sv
// accel_pkg: shared definitions for the frame sequencer.
//   - state_t        : sequencer states (IDLE, LOAD, COMPUTE, DRAIN)
//   - *_DEF          : default frame size and data width
//   - STAT_*_BIT     : bit positions of busy/done/err_tlast in the status read-back word
package accel_pkg;

   localparam int FRAME_WORDS_DEF = 576;   // 24x24 pixels
   localparam int DATA_W_DEF      = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_DONE_BIT = 1;
   localparam int STAT_ERR_BIT  = 2;

endpackage

// File: rtl/accel_frame_ctrl_if.sv
// accel_frame_ctrl_if: stream handshakes of the frame sequencer.
//   s_axis_tvalid/tlast (to ctrl), s_axis_tready (from ctrl)  : input stream control
//   m_axis_tvalid/tlast/tdata (from ctrl), m_axis_tready       : output stream
//   modport master : the frame controller's view
//   modport slave  : the surrounding stream endpoints' view
interface accel_frame_ctrl_if import accel_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF
);
   logic              s_axis_tvalid;
   logic              s_axis_tlast;
   logic              s_axis_tready;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tready;

   modport master (
      input  s_axis_tvalid, s_axis_tlast,
      output s_axis_tready,
      output m_axis_tvalid, m_axis_tlast, m_axis_tdata,
      input  m_axis_tready
   );

   modport slave (
      output s_axis_tvalid, s_axis_tlast,
      input  s_axis_tready,
      input  m_axis_tvalid, m_axis_tlast, m_axis_tdata,
      output m_axis_tready
   );
endinterface

// File: rtl/accel_out_skid.sv
// accel_out_skid: 2-entry output buffer between the result buffer and m_axis.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : drop all entries and any read in flight
//   rd_issue      : a result-buffer read is issued this cycle
//   rd_last       : the word being read is the frame's last word
//   rd_data       : result-buffer data (valid one cycle after rd_issue)
//   space         : another read may be issued this cycle without overflow
//   m_tvalid/m_tlast/m_tdata/m_tready : output stream, driven from the head entry
module accel_out_skid import accel_pkg::*; #(
   parameter int DW = DATA_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          rd_issue,
   input  logic          rd_last,
   input  logic [DW-1:0] rd_data,
   output logic          space,
   output logic          m_tvalid,
   output logic          m_tlast,
   output logic [DW-1:0] m_tdata,
   input  logic          m_tready
);
   logic [DW-1:0] data_reg [2];
   logic          last_reg [2];
   logic          wr_ptr_reg;
   logic          rd_ptr_reg;
   logic [1:0]    count_reg;
   logic          inflight_reg;
   logic          inflight_last_reg;
   logic          push;
   logic          pop;
   logic [2:0]    load;

   assign pop  = (count_reg != 2'd0) && m_tready;
   assign push = inflight_reg;

   // Credit counts the word that leaves this cycle, so a full-rate stream
   // keeps exactly one entry plus one read in flight.
   assign load  = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
   assign space = (load < 3'd2);

   assign m_tvalid = (count_reg != 2'd0);
   assign m_tdata  = data_reg[rd_ptr_reg];
   assign m_tlast  = last_reg[rd_ptr_reg] & m_tvalid;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            data_reg[i] <= '0;
            last_reg[i] <= 1'b0;
         end
         wr_ptr_reg        <= 1'b0;
         rd_ptr_reg        <= 1'b0;
         count_reg         <= 2'd0;
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
      end else if (flush) begin
         // A read returning after the flush is ignored because inflight clears.
         wr_ptr_reg        <= 1'b0;
         rd_ptr_reg        <= 1'b0;
         count_reg         <= 2'd0;
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
      end else begin
         inflight_reg      <= rd_issue;
         inflight_last_reg <= rd_last;
         if (push) begin
            data_reg[wr_ptr_reg] <= rd_data;
            last_reg[wr_ptr_reg] <= inflight_last_reg;
            wr_ptr_reg           <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/accel_frame_ctrl.sv
// accel_frame_ctrl: frame sequencer for the editing accelerator.
// Loads one FRAME_WORDS frame from the input stream into the frame buffer,
// pulses the compute core, then drains the result buffer to the output stream.
//   clk, rst                  : clock, synchronous active-high reset
//   ctrl_start, ctrl_abort    : control pulses (abort wins, start only from IDLE)
//   axis (master modport)     : input stream tvalid/tlast/tready, output stream tvalid/tlast/tdata/tready
//   buf_wr_en, buf_wr_addr    : frame-buffer write strobe/address (tdata goes straight to the buffer)
//   core_start, core_done     : compute core handshake pulses
//   buf_rd_en, buf_rd_addr    : result-buffer read, buf_rd_data returns one cycle later
//   busy, done, err_tlast     : status read-back
//   perf_cycles               : compute-phase cycles; only counts when ACCEL_FRAME_CTRL_PERF_EN is defined
module accel_frame_ctrl import accel_pkg::*; #(
   parameter int FRAME_WORDS = FRAME_WORDS_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = $clog2(FRAME_WORDS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ctrl_start,
   input  logic                 ctrl_abort,
   accel_frame_ctrl_if.master   axis,
   output logic                 buf_wr_en,
   output logic [ADDR_W-1:0]    buf_wr_addr,
   output logic                 core_start,
   input  logic                 core_done,
   output logic                 buf_rd_en,
   output logic [ADDR_W-1:0]    buf_rd_addr,
   input  logic [DATA_W-1:0]    buf_rd_data,
   output logic                 busy,
   output logic                 done,
   output logic                 err_tlast,
   output logic [31:0]          perf_cycles
);
   localparam int CNT_W = $clog2(FRAME_WORDS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_WORDS);

   state_t             state_reg;
   logic [CNT_W-1:0]   wr_cnt_reg;
   logic [CNT_W-1:0]   rd_cnt_reg;
   logic               tready_reg;
   logic               core_start_reg;
   logic               done_reg;
   logic               err_reg;

   logic               beat;
   logic               start_ok;
   logic               skid_flush;
   logic               skid_space;
   logic               m_valid;
   logic               m_last;
   logic [DATA_W-1:0]  m_data;

   assign beat       = axis.s_axis_tvalid & tready_reg;
   assign start_ok   = (state_reg == IDLE) & ctrl_start & ~ctrl_abort;
   assign skid_flush = ctrl_abort | start_ok;

   assign buf_wr_en   = beat;
   assign buf_wr_addr = wr_cnt_reg[ADDR_W-1:0];

   // Reads are gated by abort so nothing new enters the pipe while flushing.
   assign buf_rd_en   = (state_reg == DRAIN) & ~ctrl_abort & skid_space &
                        (rd_cnt_reg < FULL_CNT);
   assign buf_rd_addr = rd_cnt_reg[ADDR_W-1:0];

   assign axis.s_axis_tready = tready_reg;
   assign axis.m_axis_tvalid = m_valid;
   assign axis.m_axis_tlast  = m_last;
   assign axis.m_axis_tdata  = m_data;

   assign core_start = core_start_reg;
   assign busy       = (state_reg != IDLE);
   assign done       = done_reg;
   assign err_tlast  = err_reg;

   accel_out_skid #(.DW(DATA_W)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .flush    (skid_flush),
      .rd_issue (buf_rd_en),
      .rd_last  (rd_cnt_reg == LAST_CNT),
      .rd_data  (buf_rd_data),
      .space    (skid_space),
      .m_tvalid (m_valid),
      .m_tlast  (m_last),
      .m_tdata  (m_data),
      .m_tready (axis.m_axis_tready)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         wr_cnt_reg     <= '0;
         rd_cnt_reg     <= '0;
         tready_reg     <= 1'b0;
         core_start_reg <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
      end else if (ctrl_abort) begin
         state_reg      <= IDLE;
         wr_cnt_reg     <= '0;
         rd_cnt_reg     <= '0;
         tready_reg     <= 1'b0;
         core_start_reg <= 1'b0;
      end else begin
         core_start_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (ctrl_start) begin
                  state_reg  <= LOAD;
                  wr_cnt_reg <= '0;
                  rd_cnt_reg <= '0;
                  tready_reg <= 1'b1;
                  done_reg   <= 1'b0;
                  err_reg    <= 1'b0;
               end
            end
            LOAD: begin
               if (beat) begin
                  if (wr_cnt_reg == LAST_CNT) begin
                     // Last word: a missing tlast is flagged but the frame still runs.
                     wr_cnt_reg     <= FULL_CNT;
                     tready_reg     <= 1'b0;
                     core_start_reg <= 1'b1;
                     state_reg      <= COMPUTE;
                     if (!axis.s_axis_tlast) begin
                        err_reg <= 1'b1;
                     end
                  end else if (axis.s_axis_tlast) begin
                     // Short frame: the beat is written, then the frame is dropped.
                     wr_cnt_reg <= wr_cnt_reg + 1'b1;
                     tready_reg <= 1'b0;
                     err_reg    <= 1'b1;
                     state_reg  <= IDLE;
                  end else begin
                     wr_cnt_reg <= wr_cnt_reg + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               if (core_done) begin
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (buf_rd_en) begin
                  rd_cnt_reg <= rd_cnt_reg + 1'b1;
               end
               if (m_valid && axis.m_axis_tready && m_last) begin
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef ACCEL_FRAME_CTRL_PERF_EN
   logic [31:0] perf_reg;

   // Every COMPUTE cycle lies between core_start and core_done inclusive.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_reg <= '0;
      end else if (start_ok) begin
         perf_reg <= '0;
      end else if ((state_reg == COMPUTE) && !ctrl_abort) begin
         perf_reg <= perf_reg + 32'd1;
      end
   end

   assign perf_cycles = perf_reg;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_accel_frame_ctrl.sv
module tb_accel_frame_ctrl;
   import accel_pkg::*;

   localparam int FW   = 576;
   localparam int LAST = FW - 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        ctrl_start, ctrl_abort;
   logic        buf_wr_en, buf_rd_en, core_start, core_done;
   logic [9:0]  buf_wr_addr, buf_rd_addr;
   logic [31:0] buf_rd_data;
   logic        busy, done, err_tlast;
   logic [31:0] perf_cycles;

   accel_frame_ctrl_if axis_if ();

   accel_frame_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .ctrl_start  (ctrl_start),
      .ctrl_abort  (ctrl_abort),
      .axis        (axis_if),
      .buf_wr_en   (buf_wr_en),
      .buf_wr_addr (buf_wr_addr),
      .core_start  (core_start),
      .core_done   (core_done),
      .buf_rd_en   (buf_rd_en),
      .buf_rd_addr (buf_rd_addr),
      .buf_rd_data (buf_rd_data),
      .busy        (busy),
      .done        (done),
      .err_tlast   (err_tlast),
      .perf_cycles (perf_cycles)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [7:0]  salt = 8'h00;

   // Result-buffer contents are a known function of address and a per-frame salt.
   function automatic logic [31:0] word_of(input int idx, input logic [7:0] s);
      return {s, 8'h5A, idx[15:0]};
   endfunction

   always @(posedge clk) begin
      if (buf_rd_en) buf_rd_data <= word_of(int'(buf_rd_addr), salt);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor state (owned by the single stimulus/check process).
   int          exp_wr, exp_rd, exp_out, cs_cnt, last_cnt;
   logic        prev_stall = 1'b0, abort_prev = 1'b0, prev_last = 1'b0;
   logic [31:0] prev_data = '0;

   task automatic monitor();
      if (ctrl_start && !ctrl_abort && !busy) begin
         exp_wr = 0; exp_rd = 0; exp_out = 0; cs_cnt = 0; last_cnt = 0;
      end
      if (buf_wr_en) begin
         chk("wr_addr", 32'(buf_wr_addr), 32'(exp_wr));
         exp_wr++;
      end
      if (buf_rd_en) begin
         chk("rd_addr", 32'(buf_rd_addr), 32'(exp_rd));
         exp_rd++;
      end
      if (prev_stall && !abort_prev) begin
         chk("hold_valid", 32'(axis_if.m_axis_tvalid), 32'd1);
         chk("hold_data", axis_if.m_axis_tdata, prev_data);
         chk("hold_last", 32'(axis_if.m_axis_tlast), 32'(prev_last));
      end
      if (axis_if.m_axis_tvalid && axis_if.m_axis_tready) begin
         chk("out_data", axis_if.m_axis_tdata, word_of(exp_out, salt));
         chk("out_last", 32'(axis_if.m_axis_tlast), 32'(exp_out == LAST));
         if (axis_if.m_axis_tlast) last_cnt++;
         exp_out++;
      end
      if (core_start) cs_cnt++;
      prev_stall = axis_if.m_axis_tvalid && !axis_if.m_axis_tready;
      prev_data  = axis_if.m_axis_tdata;
      prev_last  = axis_if.m_axis_tlast;
      abort_prev = ctrl_abort;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 90000) begin
         $display("FAIL cycle_budget: got=%0d want<90000", cyc);
         $fatal(1, "cycle budget exhausted");
      end
   endtask

   task automatic run_frame(input string tag, input int tlast_at, input int delay,
                            input int tv_pct, input int tr_pct, input int abort_at);
      int  beats, guard, n;
      bit  early, acc, tv, aborted;
      logic exp_err;
      exp_err = (tlast_at != LAST);
      salt = 8'($urandom_range(0, 255));
      ctrl_start = 1'b1;
      tick();
      ctrl_start = 1'b0;
      chk({tag, "_tready_rise"}, 32'(axis_if.s_axis_tready), 32'd1);
      chk({tag, "_busy_load"}, 32'(busy), 32'd1);
      chk({tag, "_done_clr"}, 32'(done), 32'd0);

      beats = 0; guard = 0; early = 0;
      while (beats < FW && !early && guard < 20000) begin
         tv = ($urandom_range(0, 99) < tv_pct);
         axis_if.s_axis_tvalid = tv;
         axis_if.s_axis_tlast  = tv && (beats == tlast_at);
         acc = tv && axis_if.s_axis_tready;
         tick();
         if (acc) begin
            if (beats == tlast_at && tlast_at < LAST) early = 1;
            beats++;
         end
         guard++;
      end
      axis_if.s_axis_tvalid = 1'b0;
      axis_if.s_axis_tlast  = 1'b0;
      if (guard >= 20000) chk({tag, "_load_timeout"}, 32'(beats), 32'(FW));

      if (early) begin
         chk({tag, "_early_tready"}, 32'(axis_if.s_axis_tready), 32'd0);
         chk({tag, "_early_busy"}, 32'(busy), 32'd0);
         chk({tag, "_early_err"}, 32'(err_tlast), 32'd1);
         chk({tag, "_early_done"}, 32'(done), 32'd0);
         repeat (5) tick();
         chk({tag, "_early_no_core"}, 32'(cs_cnt), 32'd0);
         chk({tag, "_early_writes"}, 32'(exp_wr), 32'(tlast_at + 1));
         return;
      end

      chk({tag, "_core_start"}, 32'(core_start), 32'd1);
      chk({tag, "_tready_fall"}, 32'(axis_if.s_axis_tready), 32'd0);
      chk({tag, "_err_after_load"}, 32'(err_tlast), 32'(exp_err));
      for (int i = 0; i < delay; i++) begin
         // A start while busy must be ignored.
         ctrl_start = (i == 1);
         tick();
      end
      ctrl_start = 1'b0;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk({tag, "_drain_c0_valid"}, 32'(axis_if.m_axis_tvalid), 32'd0);

      n = 0; guard = 0; aborted = 0;
      while (!done && guard < 20000) begin
         if (abort_at >= 0 && exp_out >= abort_at) begin
            axis_if.m_axis_tready = 1'b0;
            ctrl_abort = 1'b1;
            tick();
            ctrl_abort = 1'b0;
            chk({tag, "_abort_valid"}, 32'(axis_if.m_axis_tvalid), 32'd0);
            chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
            chk({tag, "_abort_count"}, 32'(exp_out), 32'(abort_at));
            aborted = 1;
            break;
         end
         axis_if.m_axis_tready = ($urandom_range(0, 99) < tr_pct);
         tick();
         n++;
         guard++;
         if (n == 1) chk({tag, "_drain_c1_valid"}, 32'(axis_if.m_axis_tvalid), 32'd0);
         if (n == 2) chk({tag, "_drain_c2_valid"}, 32'(axis_if.m_axis_tvalid), 32'd1);
      end
      axis_if.m_axis_tready = 1'b0;
      if (aborted) begin
         repeat (4) tick();
         chk({tag, "_abort_idle_valid"}, 32'(axis_if.m_axis_tvalid), 32'd0);
         chk({tag, "_abort_done_kept"}, 32'(done), 32'd0);
         return;
      end
      if (guard >= 20000) chk({tag, "_drain_timeout"}, 32'(done), 32'd1);
      if (tr_pct == 100) chk({tag, "_drain_cycles"}, 32'(n), 32'd578);
      chk({tag, "_out_words"}, 32'(exp_out), 32'd576);
      chk({tag, "_rd_words"}, 32'(exp_rd), 32'd576);
      chk({tag, "_wr_words"}, 32'(exp_wr), 32'd576);
      chk({tag, "_tlast_cnt"}, 32'(last_cnt), 32'd1);
      chk({tag, "_core_pulses"}, 32'(cs_cnt), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_err_end"}, 32'(err_tlast), 32'(exp_err));
`ifdef ACCEL_FRAME_CTRL_PERF_EN
      chk({tag, "_perf"}, perf_cycles, 32'(delay + 1));
`else
      chk({tag, "_perf"}, perf_cycles, 32'd0);
`endif
      tick();
   endtask

   initial begin
      rst = 1'b1;
      ctrl_start = 1'b0; ctrl_abort = 1'b0; core_done = 1'b0;
      axis_if.s_axis_tvalid = 1'b0;
      axis_if.s_axis_tlast  = 1'b0;
      axis_if.m_axis_tready = 1'b0;
      exp_wr = 0; exp_rd = 0; exp_out = 0; cs_cnt = 0; last_cnt = 0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_s_tready", 32'(axis_if.s_axis_tready), 32'd0);
      chk("rst_m_tvalid", 32'(axis_if.m_axis_tvalid), 32'd0);
      chk("rst_m_tlast", 32'(axis_if.m_axis_tlast), 32'd0);
      chk("rst_m_tdata", axis_if.m_axis_tdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err_tlast), 32'd0);
      chk("rst_core_start", 32'(core_start), 32'd0);
      chk("rst_rd_en", 32'(buf_rd_en), 32'd0);
      chk("rst_perf", perf_cycles, 32'd0);
      chk("model_pin", word_of(575, 8'h03), 32'h035A023F);

      run_frame("nominal",   575, 10, 100, 100, -1);
      run_frame("backpress", 575,  3,  70,  50, -1);
      run_frame("early",     100,  0,  80, 100, -1);
      run_frame("missing",    -1,  5, 100,  60, -1);
      run_frame("abort",     575,  2, 100,  70, 300);

      // Abort together with start: abort wins, nothing starts.
      ctrl_start = 1'b1; ctrl_abort = 1'b1;
      tick();
      ctrl_start = 1'b0; ctrl_abort = 1'b0;
      chk("start_abort_busy", 32'(busy), 32'd0);
      chk("start_abort_tready", 32'(axis_if.s_axis_tready), 32'd0);

      run_frame("clean",     575, 25,  90, 100, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/accel_frame_ctrl.md
# accel_frame_ctrl

Frame sequencer for the editing accelerator. Sits between the AXI-Lite control registers and the stream datapath: admits exactly one frame of FRAME_WORDS words from the slave AXI-Stream into the frame buffer, starts the compute core, then drains the result buffer to the master AXI-Stream with a correct tlast. It owns all handshake, addressing and status; pixel data passes through the buffer, not through control logic.

## Interface
- FRAME_WORDS, 576, words per frame (24x24 pixels, 32-bit each)
- DATA_W, 32, stream and buffer data width
- ADDR_W, $clog2(FRAME_WORDS), buffer address width
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- ctrl_start  in  1  one-cycle pulse from the control register write (reg0 bit0)
- ctrl_abort  in  1  one-cycle pulse; cancels the frame in any state
- s_axis_tvalid / s_axis_tlast  in  1 / 1  input stream handshake
- s_axis_tready  out  1  input stream ready
- buf_wr_en / buf_wr_addr  out  1 / ADDR_W  input buffer write strobe and address (tdata wired straight to buffer)
- core_start  out  1  one-cycle compute start pulse
- core_done  in  1  one-cycle compute finished pulse
- buf_rd_en / buf_rd_addr  out  1 / ADDR_W  result buffer read; data returns 1 cycle later
- buf_rd_data  in  DATA_W  result buffer read data
- m_axis_tvalid / m_axis_tlast  out  1 / 1  output stream valid/last
- m_axis_tdata  out  DATA_W  output stream data
- m_axis_tready  in  1  output stream ready
- busy / done / err_tlast  out  1 / 1 / 1  status for the register read-back
- perf_cycles  out  32  compute-phase cycle count (see Configuration)

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN.
- IDLE: s_axis_tready=0. ctrl_start -> LOAD, clears done and err_tlast, zeroes wr/rd counters.
- LOAD: s_axis_tready=1. Each tvalid&tready beat: buf_wr_en=1, buf_wr_addr=wr_cnt, wr_cnt+1.
  - Beat FRAME_WORDS-1: s_axis_tready falls in the next cycle. If tlast=1, go to COMPUTE. If tlast=0, set err_tlast and still go to COMPUTE (missing tlast).
  - tlast on any earlier beat: set err_tlast, write that beat, discard the frame, return to IDLE (done stays 0).
- COMPUTE: core_start pulses on the first cycle only. Wait for core_done, then go to DRAIN. A core_done in the same cycle as core_start counts.
- DRAIN: 2-entry output skid. Issue a read (buf_rd_en, buf_rd_addr=rd_cnt) when skid occupancy plus reads in flight is less than 2 and rd_cnt<FRAME_WORDS.
  - m_axis_tdata/tvalid come from the skid head. m_axis_tlast=1 only with word FRAME_WORDS-1.
  - After the tlast beat is accepted: done=1, go to IDLE.
- ctrl_abort (any state): IDLE on the next edge. Skid flushed, counters zeroed, tready/tvalid/core_start low, done unchanged. Abort has priority over a simultaneous start.
- ctrl_start outside IDLE is ignored.
- busy=1 in all states other than IDLE.

## Timing
- Reset values: every output 0, state IDLE, counters 0, skid empty.
- s_axis_tready rises the cycle after ctrl_start is sampled.
- Write path is combinational from the input handshake: buf_wr_en = s_axis_tvalid & s_axis_tready.
- core_start is registered: 1 cycle after the last input beat.
- First m_axis_tvalid appears 2 cycles after entering DRAIN. With tready held high, throughput is 1 word/cycle.
- m_axis_tdata/tvalid/tlast stay stable while tvalid&!tready (AXI-Stream rule).
- Counters saturate at FRAME_WORDS; addresses never wrap within a frame.

## Configuration
- ACCEL_FRAME_CTRL_PERF_EN defined: perf_cycles counts clk cycles from core_start through core_done inclusive. It is cleared on ctrl_start and holds its value after the frame.
- Not defined: perf_cycles is tied to 0 and no counter is synthesized.

## Structure
- Shared package accel_pkg: state enum (IDLE/LOAD/COMPUTE/DRAIN), FRAME_WORDS and DATA_W defaults, status bit positions for the register read-back.
- One natural sub-module: accel_out_skid. It is the 2-entry output buffer with in-flight credit, taking buf_rd_data and driving m_axis_*.

## Test plan
- Nominal: start, 576 beats of 0x01010101 with tlast on beat 575, core_done 10 cycles after core_start, tready=1 -> 576 output beats, tlast only on beat 575, done=1, err_tlast=0.
- Backpressure: toggle m_axis_tready 1-0-0-1 pseudo-randomly during DRAIN -> no lost or duplicated words, addresses 0..575 read in order, data held stable while stalled.
- Early tlast on beat 100 -> err_tlast=1, no core_start, state IDLE, done=0, tready=0 on the following cycle.
- Missing tlast on beat 575 -> err_tlast=1, core_start still pulses, full 576-word drain with tlast on the last word.
- Abort mid-DRAIN after 300 words -> m_axis_tvalid=0 next cycle, busy=0. A fresh start then runs a complete clean frame.
- PERF_EN defined, core_done 25 cycles after core_start -> perf_cycles=26. Macro undefined -> perf_cycles=0.
